// File: rtl/posit_defines.sv
// ---------------------------------------------------------------------------
// posit_defines
// Shared constants, types and helpers for the posit<4,0> quire back-end.
//   POSIT4_*      : special posit<4,0> bit patterns
//   QUIRE4_BPP    : binary point position of the quire (LSB weight 2^-4)
//   QUIRE4_LUT_W  : magnitude bits seen by the rounding map
//   beat_tags_t   : NaR/sow/eow flags travelling with each beat
// ---------------------------------------------------------------------------
package posit_defines;

   localparam logic [3:0]  POSIT4_NAR    = 4'b1000;
   localparam logic [3:0]  POSIT4_MAXPOS = 4'b0111;
   localparam logic [3:0]  POSIT4_MINPOS = 4'b0001;
   localparam int unsigned QUIRE4_BPP    = 4;
   // Fraction bits plus two integer bits: every magnitude below 4.0 fits.
   localparam int unsigned QUIRE4_LUT_W  = QUIRE4_BPP + 2;

   typedef struct packed {
      logic nar;
      logic sow;
      logic eow;
   } beat_tags_t;

   // Two's-complement negate of a positive pattern (mod 16) when sign is set.
   function automatic logic [3:0] posit4_apply_sign(input logic sign, input logic [3:0] p);
      return sign ? (4'd0 - p) : p;
   endfunction

endpackage

// File: rtl/quire_to_posit_4_0_if.sv
// ---------------------------------------------------------------------------
// quire_to_posit_4_0_if
// Stream bundle for the quire-to-posit converter.
//   Upstream   : rts_i, rtr_o, sow_i, eow_i, quire_i, NaR_i
//   Downstream : rtr_i, rts_o, sow_o, eow_o, posit_o, NaR_o, sign_o, zero_o
//   slave  modport : converter view
//   master modport : environment view (drives the _i signals)
// ---------------------------------------------------------------------------
interface quire_to_posit_4_0_if #(
   parameter int unsigned QUIRE_SIZE = 19
);
   logic                  rts_i;
   logic                  rtr_o;
   logic                  sow_i;
   logic                  eow_i;
   logic [QUIRE_SIZE-1:0] quire_i;
   logic                  NaR_i;
   logic                  rtr_i;
   logic                  rts_o;
   logic                  sow_o;
   logic                  eow_o;
   logic [3:0]            posit_o;
   logic                  NaR_o;
   logic                  sign_o;
   logic                  zero_o;

   modport slave (
      input  rts_i, sow_i, eow_i, quire_i, NaR_i, rtr_i,
      output rtr_o, rts_o, sow_o, eow_o, posit_o, NaR_o, sign_o, zero_o
   );

   modport master (
      output rts_i, sow_i, eow_i, quire_i, NaR_i, rtr_i,
      input  rtr_o, rts_o, sow_o, eow_o, posit_o, NaR_o, sign_o, zero_o
   );
endinterface

// File: rtl/quire4_round_lut.sv
// ---------------------------------------------------------------------------
// quire4_round_lut
// Combinational round-to-nearest (ties to even pattern) of a 6-bit quire
// magnitude (units of 2^-4, range 0..63/16) to the low 3 bits of a positive
// posit<4,0> pattern. Nonzero inputs never map to zero.
//   i_mag : magnitude, LSB = 2^-4
//   o_p   : positive pattern bits [2:0]
// ---------------------------------------------------------------------------
module quire4_round_lut
   import posit_defines::*;
(
   input  logic [QUIRE4_LUT_W-1:0] i_mag,
   output logic [2:0]              o_p
);

   // Representable values in sixteenths: 4,8,12,16,24,32,64. Each bound is a
   // midpoint; a tie goes to the even pattern on either side.
   always_comb begin
      o_p = 3'd0;
      if (i_mag == 6'd0) begin
         o_p = 3'd0;
      end else if (i_mag <= 6'd5) begin
         o_p = POSIT4_MINPOS[2:0];
      end else if (i_mag <= 6'd10) begin
         o_p = 3'd2;
      end else if (i_mag <= 6'd13) begin
         o_p = 3'd3;
      end else if (i_mag <= 6'd20) begin
         o_p = 3'd4;
      end else if (i_mag <= 6'd27) begin
         o_p = 3'd5;
      end else if (i_mag <= 6'd48) begin
         o_p = 3'd6;
      end else begin
         o_p = 3'd7;
      end
   end

endmodule

// File: rtl/quire_to_posit_4_0.sv
// ---------------------------------------------------------------------------
// quire_to_posit_4_0
// Converts a two's-complement quire (LSB = 2^-4) with NaR/sow/eow tags into a
// posit<4,0> over an rts/rtr stream. Two register stages (magnitude, then
// encode) with a one-entry skid buffer absorbing the beat that slips in while
// the registered rtr_o catches up with downstream backpressure.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : stream bundle (slave view), see quire_to_posit_4_0_if
// Parameters:
//   QUIRE_SIZE : quire width (>= 7)
//   EOW_ONLY   : 1 = forward only eow beats, drop the rest
// ---------------------------------------------------------------------------
module quire_to_posit_4_0
   import posit_defines::*;
#(
   parameter int unsigned QUIRE_SIZE = 19,
   parameter bit          EOW_ONLY   = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   quire_to_posit_4_0_if.slave bus
);

   localparam int unsigned MSB = QUIRE_SIZE - 1;

   // Handshake
   logic                    w_process_en;
   logic                    w_xfer;
   logic                    r_rtr;

   // Skid buffer
   logic                    r_skid_valid;
   logic [QUIRE_SIZE-1:0]   r_skid_quire;
   beat_tags_t              r_skid_tags;

   // Stage-1 source and datapath
   beat_tags_t              w_in_tags;
   logic                    w_src_valid;
   logic [QUIRE_SIZE-1:0]   w_src_quire;
   beat_tags_t              w_src_tags;
   logic                    w_src_keep;
   logic                    w_sign;
   logic [QUIRE_SIZE-1:0]   w_mag;
   logic                    w_sat;
   logic                    w_zero;

   // Stage-1 registers
   logic                    r_s1_valid;
   logic                    r_s1_sign;
   logic                    r_s1_sat;
   logic                    r_s1_zero;
   logic [QUIRE4_LUT_W-1:0] r_s1_mag;
   beat_tags_t              r_s1_tags;

   // Stage-2 datapath and output registers
   logic [2:0]              w_lut_p;
   logic [3:0]              w_p;
   logic [3:0]              w_posit;
   logic                    r_rts;
   logic [3:0]              r_posit;
   logic                    r_zero;
   beat_tags_t              r_out_tags;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   assign w_process_en = bus.rtr_i | ~r_rts;
   assign w_xfer       = bus.rts_i & r_rtr;

   // rtr_o is registered, so it reacts to a stall one cycle late; the skid
   // entry holds the single beat that can arrive in that window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rtr <= 1'b0;
      end else begin
         r_rtr <= w_process_en & ~r_skid_valid;
      end
   end

   // ------------------------------------------------------------------------
   // Skid buffer
   // ------------------------------------------------------------------------
   assign w_in_tags = {bus.NaR_i, bus.sow_i, bus.eow_i};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_skid_valid <= 1'b0;
         r_skid_quire <= '0;
         r_skid_tags  <= '0;
      end else if (w_process_en) begin
         // Any held beat drains into stage 1 this cycle.
         r_skid_valid <= 1'b0;
      end else if (w_xfer) begin
         r_skid_valid <= 1'b1;
         r_skid_quire <= bus.quire_i;
         r_skid_tags  <= w_in_tags;
      end
   end

   // Skid entry is older than anything on the port, so it goes first.
   assign w_src_valid = r_skid_valid | w_xfer;
   assign w_src_quire = r_skid_valid ? r_skid_quire : bus.quire_i;
   assign w_src_tags  = r_skid_valid ? r_skid_tags  : w_in_tags;
   assign w_src_keep  = ~EOW_ONLY | w_src_tags.eow;

   // ------------------------------------------------------------------------
   // Stage 1: sign / magnitude / saturation detect
   // ------------------------------------------------------------------------
   assign w_sign = w_src_quire[MSB];
   // Unsigned result, so the most negative quire yields 2^(QUIRE_SIZE-1).
   assign w_mag  = w_sign ? (~w_src_quire + QUIRE_SIZE'(1)) : w_src_quire;
   assign w_sat  = |w_mag[MSB:QUIRE4_LUT_W];
   assign w_zero = (w_src_quire == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_sat   <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_mag   <= '0;
         r_s1_tags  <= '0;
      end else if (w_process_en) begin
         // Dropped beats (keep=0) pass through as bubbles.
         r_s1_valid <= w_src_valid & w_src_keep;
         if (w_src_valid & w_src_keep) begin
            r_s1_sign <= w_sign;
            r_s1_sat  <= w_sat;
            r_s1_zero <= w_zero;
            r_s1_mag  <= w_mag[QUIRE4_LUT_W-1:0];
            r_s1_tags <= w_src_tags;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: round, apply sign, NaR override
   // ------------------------------------------------------------------------
   quire4_round_lut u_round_lut (
      .i_mag (r_s1_mag),
      .o_p   (w_lut_p)
   );

   assign w_p     = r_s1_sat ? POSIT4_MAXPOS : {1'b0, w_lut_p};
   assign w_posit = r_s1_tags.nar ? POSIT4_NAR : posit4_apply_sign(r_s1_sign, w_p);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rts      <= 1'b0;
         r_posit    <= 4'b0000;
         r_zero     <= 1'b1;
         r_out_tags <= '0;
      end else if (w_process_en) begin
         r_rts <= r_s1_valid;
         if (r_s1_valid) begin
            r_posit    <= w_posit;
            r_zero     <= r_s1_zero & ~r_s1_tags.nar;
            r_out_tags <= r_s1_tags;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.rtr_o   = r_rtr;
   assign bus.rts_o   = r_rts;
   assign bus.posit_o = r_posit;
   assign bus.NaR_o   = r_out_tags.nar;
   assign bus.sow_o   = r_out_tags.sow;
   assign bus.eow_o   = r_out_tags.eow;
   assign bus.sign_o  = r_posit[3];
   assign bus.zero_o  = r_zero;

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// ---------------------------------------------------------------------------
// tb_quire_to_posit_4_0
// Scoreboard bench: dut0 converts every beat (EOW_ONLY=0), dut1 forwards only
// eow beats (EOW_ONLY=1). Expected results come from a value-level rounding
// model (nearest representable posit, ties to the even pattern).
// ---------------------------------------------------------------------------
module tb_quire_to_posit_4_0;

   typedef struct {
      logic [3:0] posit;
      logic       nar;
      logic       zero;
      logic       sign;
      logic       sow;
      logic       eow;
      int         xfer_cyc;
      bit         chk_lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_out1 = 0;
   bit   bp_mode = 1'b0;
   exp_t exp0 [$];
   exp_t exp1 [$];

   int sweep [12] = '{0, 1, 6, 10, 14, 16, 20, 28, 48, 49, 64, 200000};
   int negs  [3]  = '{-20, -1, -262144};
   int bpv   [8]  = '{3, 9, -12, 30, 50, -100, 17, 4000};

   quire_to_posit_4_0_if #(.QUIRE_SIZE(19)) bus0 ();
   quire_to_posit_4_0_if #(.QUIRE_SIZE(19)) bus1 ();

   quire_to_posit_4_0 #(.QUIRE_SIZE(19), .EOW_ONLY(1'b0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   quire_to_posit_4_0 #(.QUIRE_SIZE(19), .EOW_ONLY(1'b1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Downstream ready: always 1, or random while backpressure is enabled.
   initial forever begin
      @(posedge clk);
      #1;
      if (bp_mode) bus0.rtr_i = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   function automatic longint pval(input int p);
      case (p)
         1: return 4;   // 1/4
         2: return 8;   // 1/2
         3: return 12;  // 3/4
         4: return 16;  // 1
         5: return 24;  // 3/2
         6: return 32;  // 2
         default: return 64;  // 4
      endcase
   endfunction

   function automatic exp_t model(input logic signed [18:0] q, input logic nar,
                                  input logic sow, input logic eow);
      exp_t   e;
      longint a, d, bd;
      int     best;
      e.sow = sow;
      e.eow = eow;
      e.xfer_cyc = 0;
      e.chk_lat = 1'b0;
      e.nar = nar;
      if (nar) begin
         e.posit = 4'b1000;
         e.zero  = 1'b0;
      end else if (q == 0) begin
         e.posit = 4'b0000;
         e.zero  = 1'b1;
      end else begin
         a = (q < 0) ? -longint'(q) : longint'(q);
         best = 1;
         bd = (a > pval(1)) ? a - pval(1) : pval(1) - a;
         for (int p = 2; p <= 7; p++) begin
            d = (a > pval(p)) ? a - pval(p) : pval(p) - a;
            if (d < bd || (d == bd && (p % 2) == 0)) begin
               best = p;
               bd = d;
            end
         end
         e.posit = (q < 0) ? 4'(16 - best) : 4'(best);
         e.zero  = 1'b0;
      end
      e.sign = e.posit[3];
      return e;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [3:0] rand_posit_free();
      return 4'($urandom);
   endfunction

   function automatic logic [18:0] rand_quire();
      int          v;
      logic [18:0] q;
      case ($urandom_range(0, 3))
         0: begin
            v = int'($urandom_range(0, 160)) - 80;
            q = 19'(v);
         end
         1: q = 19'($urandom);
         2: q = 19'(0);
         default: begin
            v = int'($urandom_range(0, 16)) * 4 - 32;
            q = 19'(v);
         end
      endcase
      return q;
   endfunction

   // ------------------------------------------------------------------------
   // Driver: presents one beat and waits for it to transfer.
   // ------------------------------------------------------------------------
   task automatic send(input int sel, input logic [18:0] q, input logic nar,
                       input logic sow, input logic eow);
      int   n = 0;
      bit   ok = 1'b1;
      logic rdy;
      exp_t e;
      if (sel == 0) begin
         bus0.rts_i = 1'b1; bus0.quire_i = q; bus0.NaR_i = nar;
         bus0.sow_i = sow;  bus0.eow_i = eow;
      end else begin
         bus1.rts_i = 1'b1; bus1.quire_i = q; bus1.NaR_i = nar;
         bus1.sow_i = sow;  bus1.eow_i = eow;
      end
      forever begin
         @(negedge clk);
         rdy = (sel == 0) ? bus0.rtr_o : bus1.rtr_o;
         if (rdy === 1'b1 && !rst) break;
         n++;
         if (n > 200) begin
            n_vec++;
            n_err++;
            ok = 1'b0;
            $display("FAIL xfer_timeout%0d: rtr_o low for %0d cycles, required transfer", sel, n);
            break;
         end
      end
      if (ok) begin
         e = model($signed(q), nar, sow, eow);
         e.xfer_cyc = cyc + 1;
         e.chk_lat = !bp_mode;
         if (sel == 0) exp0.push_back(e);
         else if (eow) exp1.push_back(e);
      end
      @(posedge clk);
      #1;
      if (sel == 0) bus0.rts_i = 1'b0;
      else bus1.rts_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp0.size() != 0 || exp1.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d/%0d beats outstanding, required 0",
                  exp0.size(), exp1.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------------
   // Monitors
   // ------------------------------------------------------------------------
   initial begin : mon0
      exp_t       e;
      logic [9:0] act;
      logic [9:0] hval = '0;
      bit         hv = 1'b0;
      forever begin
         @(negedge clk);
         act = {bus0.rts_o, bus0.posit_o, bus0.NaR_o, bus0.zero_o, bus0.sign_o,
                bus0.sow_o, bus0.eow_o};
         if (rst) begin
            hv = 1'b0;
         end else begin
            if (hv) chk("hold0", 16'(act), 16'(hval));
            if (bus0.rts_o && bus0.rtr_i) begin
               if (exp0.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL extra0: output %b with no beat outstanding, required none", act);
               end else begin
                  e = exp0.pop_front();
                  chk("out0", 16'(act[8:0]),
                      16'({e.posit, e.nar, e.zero, e.sign, e.sow, e.eow}));
                  if (e.chk_lat) chk("lat0", 16'(cyc + 1 - e.xfer_cyc), 16'd2);
               end
            end
            hv = bus0.rts_o & ~bus0.rtr_i;
            hval = act;
         end
      end
   end

   initial begin : mon1
      exp_t       e;
      logic [9:0] act;
      forever begin
         @(negedge clk);
         act = {bus1.rts_o, bus1.posit_o, bus1.NaR_o, bus1.zero_o, bus1.sign_o,
                bus1.sow_o, bus1.eow_o};
         if (!rst && bus1.rts_o && bus1.rtr_i) begin
            n_out1++;
            if (exp1.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL extra1: output %b with no beat outstanding, required none", act);
            end else begin
               e = exp1.pop_front();
               chk("out1", 16'(act[8:0]),
                   16'({e.posit, e.nar, e.zero, e.sign, e.sow, e.eow}));
               if (e.chk_lat) chk("lat1", 16'(cyc + 1 - e.xfer_cyc), 16'd2);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin : stim
      int base;
      bus0.rts_i = 1'b0; bus0.sow_i = 1'b0; bus0.eow_i = 1'b0; bus0.quire_i = '0;
      bus0.NaR_i = 1'b0; bus0.rtr_i = 1'b1;
      bus1.rts_i = 1'b0; bus1.sow_i = 1'b0; bus1.eow_i = 1'b0; bus1.quire_i = '0;
      bus1.NaR_i = 1'b0; bus1.rtr_i = 1'b1;

      // Reset values while reset is held.
      repeat (3) @(posedge clk);
      #1;
      chk("reset0", 16'({bus0.rts_o, bus0.rtr_o, bus0.sow_o, bus0.eow_o, bus0.posit_o,
                         bus0.NaR_o, bus0.zero_o, bus0.sign_o}), 16'(11'b00000000010));
      chk("reset1", 16'({bus1.rts_o, bus1.rtr_o, bus1.sow_o, bus1.eow_o, bus1.posit_o,
                         bus1.NaR_o, bus1.zero_o, bus1.sign_o}), 16'(11'b00000000010));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rtr_before_edge", 16'(bus0.rtr_o), 16'd0);
      @(posedge clk);
      #1;
      chk("rtr_after_edge", 16'(bus0.rtr_o), 16'd1);

      // Rounding sweep, negatives, NaR with tags; back to back.
      foreach (sweep[i]) send(0, 19'(sweep[i]), 1'b0, 1'b0, 1'b0);
      foreach (negs[i])  send(0, 19'(negs[i]), 1'b0, 1'b0, 1'b0);
      send(0, 19'(16), 1'b1, 1'b1, 1'b1);
      send(0, 19'(-16), 1'b1, 1'b0, 1'b0);
      drain();

      // EOW_ONLY window: only the eow beat comes out.
      base = n_out1;
      for (int i = 0; i < 5; i++) begin
         send(1, (i == 4) ? 19'(24) : rand_quire(), 1'b0, (i == 0), (i == 4));
      end
      drain();
      chk("eow_count", 16'(n_out1 - base), 16'd1);

      // Backpressure: 8 distinct values, then random traffic.
      @(posedge clk);
      #2;
      bp_mode = 1'b1;
      foreach (bpv[i]) send(0, 19'(bpv[i]), 1'b0, (i == 0), (i == 7));
      for (int i = 0; i < 80; i++) begin
         send(0, rand_quire(), ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #2;
      bp_mode = 1'b0;
      bus0.rtr_i = 1'b1;
      drain();

      // Random windows on the eow-only instance.
      for (int i = 0; i < 40; i++) begin
         send(1, rand_quire(), ($urandom_range(0, 7) == 0), 1'($urandom),
              ($urandom_range(0, 2) == 0));
      end
      drain();

      // Reset with two beats in flight, asserted between clock edges.
      send(0, 19'(40), 1'b0, 1'b0, 1'b0);
      send(0, 19'(-40), 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      exp0.delete();
      exp1.delete();
      #1;
      chk("rst_async_rts", 16'({bus0.rts_o, bus0.rtr_o}), 16'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rtr_after_rst", 16'(bus0.rtr_o), 16'd1);
      repeat (4) @(posedge clk);
      #1;
      send(0, 19'(16), 1'b0, 1'b1, 1'b0);
      send(0, 19'(-7), 1'b0, 1'b0, 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
